// File: rtl/serial_sub_param.sv
// serial_sub_param: digit-serial subtractor computing diff = a - b - borrow_in.
// DIGIT bits are processed per clock through a ripple of 1-bit full-subtract
// cells; the borrow is carried between cycles in a register. WIDTH/DIGIT digit
// cycles per operation, with a start/busy/done handshake.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output.
module serial_sub_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int DIGIT_SAFE = (DIGIT > 0) ? DIGIT : 1;
    localparam int N          = WIDTH / DIGIT_SAFE;
    localparam int CNT_W      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Refuse to elaborate a geometry that cannot be split into whole digits.
    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT_SAFE) != 0) begin : g_param_check
            $error("serial_sub_param: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   res_reg;
    logic [WIDTH-1:0]   res_next;
    logic               borrow_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               borrow_out_reg;
    logic               accept;
    logic               last_digit;
    logic [DIGIT_SAFE:0]   chain;
    logic [DIGIT_SAFE-1:0] d_digit;

    // Borrow ripples LSB-first across the cells of the current digit.
    assign chain[0] = borrow_reg;

    generate
        for (genvar gi = 0; gi < DIGIT_SAFE; gi++) begin : g_cell
            assign d_digit[gi]  = a_sh_reg[gi] ^ b_sh_reg[gi] ^ chain[gi];
            assign chain[gi+1]  = (~a_sh_reg[gi] & b_sh_reg[gi])
                                | (~(a_sh_reg[gi] ^ b_sh_reg[gi]) & chain[gi]);
        end
    endgenerate

    // New digit enters the result register from the MSB side.
    assign res_next   = WIDTH'({d_digit, res_reg} >> DIGIT_SAFE);
    assign last_digit = (state_reg == ST_RUN) && (cnt_reg == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and handshake outputs; DONE accepts start like IDLE.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, shift one digit per RUN cycle,
    // publish the result on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            res_reg        <= '0;
            borrow_reg     <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            res_reg    <= '0;
            borrow_reg <= borrow_in;
            cnt_reg    <= '0;
        end else if (state_reg == ST_RUN) begin
            a_sh_reg   <= a_sh_reg >> DIGIT_SAFE;
            b_sh_reg   <= b_sh_reg >> DIGIT_SAFE;
            res_reg    <= res_next;
            borrow_reg <= chain[DIGIT_SAFE];
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_digit) begin
                diff_reg       <= res_next;
                borrow_out_reg <= chain[DIGIT_SAFE];
            end
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    // Operand sign bits are kept aside because the shift registers are consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (last_digit) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (res_next[WIDTH-1] != a_msb_reg);
        end
    end

    assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_sub_param.sv
// Testbench for serial_sub_param: two instances (WIDTH=8 with DIGIT=1 and
// DIGIT=4) checked against an arithmetic reference model.
module tb_serial_sub_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_s [2];
    logic [7:0] a_s     [2];
    logic [7:0] b_s     [2];
    logic       bin_s   [2];
    logic       busy_s  [2];
    logic       done_s  [2];
    logic [7:0] diff_s  [2];
    logic       bo_s    [2];
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf_s   [2];
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub_param #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .borrow_in(bin_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .diff(diff_s[0]), .borrow_out(bo_s[0])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(ovf_s[0])
`endif
    );

    serial_sub_param #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .borrow_in(bin_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .diff(diff_s[1]), .borrow_out(bo_s[1])
`ifdef SERIAL_SUB_OVF_EN
        , .overflow(ovf_s[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on instance s; inject>=0 raises a stray start at that RUN
    // cycle; b2b leaves the bench in the DONE cycle so the caller can chain.
    task automatic do_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                         input logic bi, input int inject, input bit b2b);
        int         n;
        int         k;
        int         busy_cnt;
        logic [7:0] exp_d;
        logic       exp_bo;
        n = (s == 0) ? 8 : 2;
        a_s[s] = av; b_s[s] = bv; bin_s[s] = bi; start_s[s] = 1'b1;
        step();
        start_s[s] = 1'b0;
        a_s[s] = 8'($urandom); b_s[s] = 8'($urandom); bin_s[s] = 1'($urandom);
        k = 0;
        busy_cnt = 0;
        while (done_s[s] !== 1'b1 && k < 40) begin
            if (busy_s[s] === 1'b1) busy_cnt++;
            if (k == inject) begin
                a_s[s] = 8'hFF; b_s[s] = 8'h01; bin_s[s] = 1'b0; start_s[s] = 1'b1;
            end else begin
                start_s[s] = 1'b0;
            end
            step();
            k++;
        end
        start_s[s] = 1'b0;
        exp_d  = 8'(int'(av) - int'(bv) - int'(bi));
        exp_bo = (int'(av) < int'(bv) + int'(bi));
        chk($sformatf("latency%0d", s), k, n);
        chk($sformatf("busy_cycles%0d", s), busy_cnt, n);
        chk($sformatf("diff%0d", s), diff_s[s], exp_d);
        chk($sformatf("borrow_out%0d", s), bo_s[s], exp_bo);
`ifdef SERIAL_SUB_OVF_EN
        begin
            int sd;
            int sa;
            int sb;
            sa = int'($signed(av));
            sb = int'($signed(bv));
            sd = sa - sb - int'(bi);
            chk($sformatf("overflow%0d", s), ovf_s[s], (sd < -128 || sd > 127));
        end
`endif
        $display("op dut%0d a=%02h b=%02h bin=%0d -> diff=%02h bo=%0d (exp %02h/%0d)",
                 s, av, bv, bi, diff_s[s], bo_s[s], exp_d, exp_bo);
        if (!b2b) begin
            step();
            chk($sformatf("done_pulse%0d", s), done_s[s], 1'b0);
            chk($sformatf("idle_busy%0d", s), busy_s[s], 1'b0);
            chk($sformatf("diff_held%0d", s), diff_s[s], exp_d);
            chk($sformatf("bo_held%0d", s), bo_s[s], exp_bo);
        end
    endtask

    initial begin
        int done_seen;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; a_s[i] = 8'h00; b_s[i] = 8'h00; bin_s[i] = 1'b0;
        end
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_busy%0d", i), busy_s[i], 1'b0);
            chk($sformatf("rst_done%0d", i), done_s[i], 1'b0);
            chk($sformatf("rst_diff%0d", i), diff_s[i], 8'h00);
            chk($sformatf("rst_bo%0d", i), bo_s[i], 1'b0);
        end
        rst = 1'b0;
        step();

        // Directed cases on the bit-serial instance.
        do_op(0, 8'h5A, 8'h23, 1'b0, -1, 1'b0);
        do_op(0, 8'h10, 8'h20, 1'b0, -1, 1'b0);
        do_op(0, 8'h00, 8'h00, 1'b1, -1, 1'b0);
        // Stray start three cycles into RUN must be ignored.
        do_op(0, 8'h5A, 8'h23, 1'b0, 3, 1'b0);
        // start held in DONE launches the next op with no IDLE cycle.
        do_op(0, 8'hC3, 8'h3C, 1'b1, -1, 1'b1);
        do_op(0, 8'h01, 8'h02, 1'b0, -1, 1'b0);

        // Reset in the middle of RUN aborts with no done pulse.
        a_s[0] = 8'h77; b_s[0] = 8'h11; bin_s[0] = 1'b0; start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy_s[0], 1'b0);
        chk("midrst_done", done_s[0], 1'b0);
        chk("midrst_diff", diff_s[0], 8'h00);
        chk("midrst_bo", bo_s[0], 1'b0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_s[0] === 1'b1) done_seen++;
            step();
        end
        chk("midrst_no_done", done_seen, 0);
        do_op(0, 8'h77, 8'h11, 1'b0, -1, 1'b0);

        // Digit-of-four instance.
        do_op(1, 8'hA5, 8'h5A, 1'b1, -1, 1'b0);
        do_op(1, 8'h00, 8'h00, 1'b1, 0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        do_op(0, 8'h80, 8'h01, 1'b0, -1, 1'b0);
        do_op(0, 8'h05, 8'h03, 1'b0, -1, 1'b0);
        do_op(1, 8'h80, 8'h01, 1'b0, -1, 1'b0);
`endif

        // Randomized operations, with random back-to-back chaining.
        for (int i = 0; i < 1000; i++) begin
            do_op(1, 8'($urandom), 8'($urandom), 1'($urandom), -1,
                  (i != 999) && ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 100; i++) begin
            do_op(0, 8'($urandom), 8'($urandom), 1'($urandom), -1,
                  (i != 99) && ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
